// File: rtl/ddrlink.sv
// Half-duplex byte transceiver for one bidirectional DDR pad.
// Sends 6-pair frames (START, 4 data pairs MSB first, STOP) and deframes received pairs.
module ddrlink #(
    parameter int GUARD = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tx_stb,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_busy,
    output logic       o_oe,
    output logic [1:0] o_v,
    input  logic [1:0] i_v,
    output logic       o_rx_stb,
    output logic [7:0] o_rx_data,
    output logic       o_rx_err
);

    localparam int GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_GUARD
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    tx_state_e tx_state_q;
    rx_state_e rx_state_q;

    logic [7:0]    tx_sh_q;
    logic [1:0]    tx_cnt_q;
    logic [GW-1:0] grd_q;
    logic          oe_q;
    logic [1:0]    v_q;

    logic [7:0] rx_sh_q;
    logic [1:0] rx_cnt_q;
    logic [7:0] rx_data_q;
    logic       rx_stb_q;
    logic       rx_err_q;

    logic tx_accept;

    assign o_tx_busy = (tx_state_q != TX_IDLE) || (rx_state_q != RX_IDLE);
    assign tx_accept = i_tx_stb && !o_tx_busy;

    assign o_oe      = oe_q;
    assign o_v       = v_q;
    assign o_rx_stb  = rx_stb_q;
    assign o_rx_err  = rx_err_q;
    assign o_rx_data = rx_data_q;

    // Each state loads the pair that the next state presents on the pad.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_state_q <= TX_IDLE;
            tx_sh_q    <= 8'h00;
            tx_cnt_q   <= 2'd0;
            grd_q      <= '0;
            oe_q       <= 1'b0;
            v_q        <= 2'b11;
        end else begin
            unique case (tx_state_q)
                TX_IDLE: begin
                    if (tx_accept) begin
                        tx_sh_q    <= i_tx_data;
                        oe_q       <= 1'b1;
                        v_q        <= 2'b00;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    v_q        <= tx_sh_q[7:6];
                    tx_sh_q    <= {tx_sh_q[5:0], 2'b00};
                    tx_cnt_q   <= 2'd0;
                    tx_state_q <= TX_DATA;
                end
                TX_DATA: begin
                    if (tx_cnt_q == 2'd3) begin
                        v_q        <= 2'b11;
                        tx_state_q <= TX_STOP;
                    end else begin
                        v_q      <= tx_sh_q[7:6];
                        tx_sh_q  <= {tx_sh_q[5:0], 2'b00};
                        tx_cnt_q <= tx_cnt_q + 2'd1;
                    end
                end
                TX_STOP: begin
                    oe_q <= 1'b0;
                    v_q  <= 2'b11;
                    if (GUARD == 0) begin
                        tx_state_q <= TX_IDLE;
                    end else begin
                        grd_q      <= GW'(GUARD);
                        tx_state_q <= TX_GUARD;
                    end
                end
                TX_GUARD: begin
                    if (grd_q == GW'(1)) begin
                        tx_state_q <= TX_IDLE;
                    end else begin
                        grd_q <= grd_q - GW'(1);
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                end
            endcase
        end
    end

    // A START pair loses to a transmit accepted in the same cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_state_q <= RX_IDLE;
            rx_sh_q    <= 8'h00;
            rx_cnt_q   <= 2'd0;
            rx_data_q  <= 8'h00;
            rx_stb_q   <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_stb_q <= 1'b0;
            rx_err_q <= 1'b0;
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (tx_state_q == TX_IDLE && !tx_accept && i_v == 2'b00) begin
                        rx_cnt_q   <= 2'd0;
                        rx_state_q <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    rx_sh_q <= {rx_sh_q[5:0], i_v};
                    if (rx_cnt_q == 2'd3) begin
                        rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 2'd1;
                    end
                end
                RX_STOP: begin
                    rx_data_q  <= rx_sh_q;
                    rx_stb_q   <= (i_v == 2'b11);
                    rx_err_q   <= (i_v != 2'b11);
                    rx_state_q <= RX_IDLE;
                end
                default: begin
                    rx_state_q <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddrlink.sv
// Scoreboard bench for ddrlink: a cycle-timeline model predicts pad pairs,
// received bytes and busy; a negedge monitor pops and compares.
module tb_ddrlink;

    localparam int G = 3;
    localparam int NCYC = 20000;

    logic       clk;
    logic       rst;
    logic       tx_stb;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       oe;
    logic [1:0] v_out;
    logic [1:0] v_in;
    logic [1:0] v_drv;
    logic       rx_stb;
    logic [7:0] rx_data;
    logic       rx_err;

    logic       loop_en;
    logic [1:0] lb0;
    logic [1:0] lb1;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int free_at = 0;

    typedef struct {
        int         c;
        logic [1:0] v;
    } txe_t;

    typedef struct {
        int         c;
        logic [7:0] d;
        logic       err;
    } rxe_t;

    txe_t tx_q[$];
    rxe_t rx_q[$];
    bit   exp_busy[NCYC];

    assign v_in = loop_en ? lb1 : v_drv;

    ddrlink #(.GUARD(G)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_tx_stb  (tx_stb),
        .i_tx_data (tx_data),
        .o_tx_busy (tx_busy),
        .o_oe      (oe),
        .o_v       (v_out),
        .i_v       (v_in),
        .o_rx_stb  (rx_stb),
        .o_rx_data (rx_data),
        .o_rx_err  (rx_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Pad wrapper round trip: two register stages from o_v back to i_v.
    always @(posedge clk) begin
        lb0 <= v_out;
        lb1 <= lb0;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < NCYC) check("busy", 32'(tx_busy), 32'(exp_busy[cyc]));
        if (oe) begin
            if (tx_q.size() == 0) begin
                check("tx_unexpected_oe", 32'(v_out), 32'hffff);
            end else begin
                txe_t e;
                e = tx_q.pop_front();
                check("tx_cycle", 32'(cyc), 32'(e.c));
                check("tx_pair", 32'(v_out), 32'(e.v));
            end
        end
        if (rx_stb || rx_err) begin
            if (rx_q.size() == 0) begin
                check("rx_unexpected", {rx_stb, rx_err, rx_data}, 32'hffff);
            end else begin
                rxe_t r;
                r = rx_q.pop_front();
                check("rx_cycle", 32'(cyc), 32'(r.c));
                check("rx_data", 32'(rx_data), 32'(r.d));
                check("rx_kind", {rx_stb, rx_err}, {!r.err, r.err});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] noise();
        return 2'($urandom_range(1, 3));
    endfunction

    task automatic mark_busy(input int a, input int b);
        for (int k = a; k <= b; k++) if (k < NCYC) exp_busy[k] = 1'b1;
    endtask

    // Byte is taken in the first cycle the link is free; stb held till then.
    task automatic send(input logic [7:0] d);
        int e;
        logic [7:0] sh;
        e = (cyc > free_at) ? cyc : free_at;
        tx_stb = 1'b1;
        tx_data = d;
        tx_q.push_back('{e + 1, 2'b00});
        sh = d;
        for (int k = 0; k < 4; k++) begin
            tx_q.push_back('{e + 2 + k, sh[7:6]});
            sh = sh << 2;
        end
        tx_q.push_back('{e + 6, 2'b11});
        mark_busy(e + 1, e + 6 + G);
        free_at = e + 7 + G;
        while (cyc < e) step();
        step();
        tx_stb = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic [1:0] stp,
                            input bit ign);
        int m;
        m = cyc;
        if (!ign) begin
            rx_q.push_back('{m + 6, d, stp != 2'b11});
            mark_busy(m + 1, m + 5);
            if (free_at < m + 6) free_at = m + 6;
        end
        v_drv = 2'b00;
        step();
        for (int k = 3; k >= 0; k--) begin
            v_drv = d[2*k +: 2];
            step();
        end
        v_drv = stp;
        step();
        v_drv = 2'b11;
    endtask

    task automatic wait_free();
        while (cyc < free_at) begin
            v_drv = noise();
            step();
        end
        v_drv = 2'b11;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_oe"}, 32'(oe), 32'h0);
        check({tag, "_v"}, 32'(v_out), 32'h3);
        check({tag, "_busy"}, 32'(tx_busy), 32'h0);
        check({tag, "_rx_stb"}, 32'(rx_stb), 32'h0);
        check({tag, "_rx_err"}, 32'(rx_err), 32'h0);
        check({tag, "_rx_data"}, 32'(rx_data), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        tx_stb = 1'b0;
        tx_data = 8'h00;
        v_drv = 2'b11;
        loop_en = 1'b0;
        step();
        step();
        reset_checks("reset");
        step();
        rst = 1'b0;
        free_at = cyc;

        send(8'hA5);
        wait_free();
        step();
        rx_frame(8'hC6, 2'b11, 1'b0);
        step();
        rx_frame(8'hC6, 2'b01, 1'b0);

        wait_free();
        loop_en = 1'b1;
        send(8'hA5);
        while (cyc < free_at + 4) step();
        loop_en = 1'b0;

        wait_free();
        fork
            rx_frame(8'hC6, 2'b11, 1'b0);
            begin
                step();
                step();
                send(8'h5A);
            end
        join

        wait_free();
        fork
            send(8'h33);
            rx_frame(8'h00, 2'b11, 1'b1);
        join

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: send(8'($urandom));
                1: begin
                    wait_free();
                    rx_frame(8'($urandom),
                             ($urandom_range(0, 3) == 0) ?
                             2'($urandom) : 2'b11, 1'b0);
                end
                default: begin
                    for (int k = $urandom_range(0, 4); k > 0; k--) begin
                        v_drv = noise();
                        step();
                    end
                    v_drv = 2'b11;
                end
            endcase
        end

        wait_free();
        send(8'hF0);
        step();
        step();
        rst = 1'b1;
        tx_q.delete();
        for (int k = cyc; k < NCYC; k++) exp_busy[k] = 1'b0;
        #1;
        reset_checks("midframe_reset");
        step();
        step();
        rst = 1'b0;
        free_at = cyc;
        send(8'h3C);

        while (cyc < free_at + 5) step();
        check("tx_queue_drained", 32'(tx_q.size()), 32'h0);
        check("rx_queue_drained", 32'(rx_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
